// File: rtl/cmp_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_share_pkg
// Description : Shared types, default sizes and helpers for the shared
//               magnitude-compare arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_share_pkg;

  // Arbiter/compare sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CMP  = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 16;

  // Widest requester vector the helper below understands
  localparam int MAX_REQ = 8;

  // Converts a one-hot (or all-zero) vector to its bit index.
  // OR-ing the indices of all set bits is exact for one-hot input.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin winner search. Starting at ptr,
//               scans upward (wrapping) for the first asserted req bit and
//               reports it as one-hot and as an index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import cmp_share_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  winner_oh,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_req
);

  logic               found;
  logic [MAX_REQ-1:0] oh_pad;

  // Scan from the pointer upward; the first set bit wins
  always_comb begin
    int idx;
    winner_oh = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner_oh[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign oh_pad  = MAX_REQ'(winner_oh);
  assign winner  = ID_WIDTH'(onehot_to_idx(oh_pad));
  assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmp_share_arbiter
// Description : Shares one magnitude comparator among NUM_REQ requesters.
//               Round-robin arbitration, operand capture, registered
//               gt/lt/eq + owner id with a one-cycle done strobe.
//               Build option: define CMP_SIGNED_EN for a two's-complement
//               compare; otherwise the compare is unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_share_arbiter
  import cmp_share_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] a_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          done,
  output logic [ID_WIDTH-1:0]           result_id,
  output logic                          gt,
  output logic                          lt,
  output logic                          eq
);

  state_t                state;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

  logic [NUM_REQ-1:0]    winner_oh;
  logic [ID_WIDTH-1:0]   winner;
  logic                  any_req;
  logic [ID_WIDTH-1:0]   ptr_next;
  logic                  a_gt_b;
  logic                  a_lt_b;
  logic                  a_eq_b;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (ptr),
    .winner_oh (winner_oh),
    .winner    (winner),
    .any_req   (any_req)
  );

  // Pointer moves one past the winner so the winner goes to the back of the line
  assign ptr_next = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

`ifdef CMP_SIGNED_EN
  assign a_gt_b = $signed(op_a) > $signed(op_b);
  assign a_lt_b = $signed(op_a) < $signed(op_b);
`else
  assign a_gt_b = op_a > op_b;
  assign a_lt_b = op_a < op_b;
`endif
  // Equality is bit-identity in both builds
  assign a_eq_b = (op_a == op_b);

  // A compare is in flight from acceptance until the done cycle ends
  assign busy = (state != IDLE);

  // Sequencer: accept a winner, capture operands, register the result
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      grant     <= '0;
      done      <= 1'b0;
      result_id <= '0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      grant <= '0;
      done  <= 1'b0;
      case (state)
        // CMP arbitrates exactly like IDLE, giving back-to-back service
        IDLE, CMP: begin
          if (any_req) begin
            op_a   <= a_in[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            op_b   <= b_in[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            grant  <= winner_oh;
            cur_id <= winner;
            ptr    <= ptr_next;
            state  <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          gt        <= a_gt_b;
          lt        <= a_lt_b;
          eq        <= a_eq_b;
          result_id <= cur_id;
          done      <= 1'b1;
          state     <= CMP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_share_arbiter
// Description : Directed self-checking bench for cmp_share_arbiter.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_share_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int ID_WIDTH   = 2;

  logic                          clk = 1'b0;
  logic                          n_rst = 1'b0;
  logic [NUM_REQ-1:0]            req = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] a_in = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] b_in = '0;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          done;
  logic [ID_WIDTH-1:0]           result_id;
  logic                          gt;
  logic                          lt;
  logic                          eq;

  int total_checks = 0;
  int pass_checks  = 0;

  cmp_share_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .result_id (result_id),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b);
    a_in[i*DATA_WIDTH +: DATA_WIDTH] = a;
    b_in[i*DATA_WIDTH +: DATA_WIDTH] = b;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    req   = '0;
    tick;
    tick;
    total_checks++;
    if ({grant, busy, done, result_id, gt, lt, eq} !== '0) begin
      $display("FAIL reset_outputs: got %b required 0", {grant, busy, done, result_id, gt, lt, eq});
    end else pass_checks++;
    n_rst = 1'b1;
    tick;
    total_checks++;
    if ({busy, grant, done} !== '0) begin
      $display("FAIL reset_idle: busy/grant/done got %b required 0", {busy, grant, done});
    end else pass_checks++;
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_res [4];
    logic [3:0] exp_g;
    int         w;
    exp_res[0] = 3'b100;
    exp_res[1] = 3'b010;
    exp_res[2] = 3'b001;
`ifdef CMP_SIGNED_EN
    exp_res[3] = 3'b010;
`else
    exp_res[3] = 3'b100;
`endif
    set_lane(0, 16'h0005, 16'h0003);
    set_lane(1, 16'h0003, 16'h0005);
    set_lane(2, 16'h0007, 16'h0007);
    set_lane(3, 16'h8000, 16'h0001);
    req = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      tick;
      w = (k / 2) % 4;
      total_checks++;
      if (k % 2 == 0) begin
        exp_g = 4'b0001 << w;
        if (grant !== exp_g || done !== 1'b0 || busy !== 1'b1) begin
          $display("FAIL rr_grant[%0d]: grant=%b done=%b busy=%b required grant=%b done=0 busy=1",
                   k, grant, done, busy, exp_g);
        end else pass_checks++;
      end else begin
        if (done !== 1'b1 || grant !== 4'b0000 || result_id !== 2'(w) ||
            {gt, lt, eq} !== exp_res[w]) begin
          $display("FAIL rr_done[%0d]: done=%b grant=%b id=%0d gtlteq=%b required done=1 grant=0 id=%0d gtlteq=%b",
                   k, done, grant, result_id, {gt, lt, eq}, w, exp_res[w]);
        end else pass_checks++;
      end
    end
    req = '0;
    tick;
    total_checks++;
    if (busy !== 1'b0 || grant !== 4'b0000 || done !== 1'b0) begin
      $display("FAIL rr_idle: busy=%b grant=%b done=%b required all 0", busy, grant, done);
    end else pass_checks++;
  endtask

  task automatic test_single;
    set_lane(2, 16'h1234, 16'h1233);
    req = 4'b0100;
    tick;
    total_checks++;
    if (grant !== 4'b0100 || busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL single_grant: grant=%b busy=%b done=%b required 0100 1 0", grant, busy, done);
    end else pass_checks++;
    req = '0;
    tick;
    total_checks++;
    if (grant !== 4'b0000 || done !== 1'b1 || result_id !== 2'd2 || {gt, lt, eq} !== 3'b100) begin
      $display("FAIL single_done: grant=%b done=%b id=%0d gtlteq=%b required 0000 1 2 100",
               grant, done, result_id, {gt, lt, eq});
    end else pass_checks++;
    tick;
    total_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result_id !== 2'd2 || {gt, lt, eq} !== 3'b100) begin
      $display("FAIL single_hold: done=%b busy=%b id=%0d gtlteq=%b required 0 0 2 100",
               done, busy, result_id, {gt, lt, eq});
    end else pass_checks++;
  endtask

  task automatic test_wrap_skip;
    // Pointer sits at 3 after the grant to requester 2
    req = 4'b0011;
    tick;
    total_checks++;
    if (grant !== 4'b0001) begin
      $display("FAIL wrap_grant0: grant=%b required 0001", grant);
    end else pass_checks++;
    req = 4'b0010;
    tick;
    total_checks++;
    if (done !== 1'b1 || result_id !== 2'd0) begin
      $display("FAIL wrap_done0: done=%b id=%0d required 1 0", done, result_id);
    end else pass_checks++;
    tick;
    total_checks++;
    if (grant !== 4'b0010) begin
      $display("FAIL wrap_grant1: grant=%b required 0010", grant);
    end else pass_checks++;
    req = '0;
    tick;
    total_checks++;
    if (done !== 1'b1 || result_id !== 2'd1) begin
      $display("FAIL wrap_done1: done=%b id=%0d required 1 1", done, result_id);
    end else pass_checks++;
    tick;
  endtask

  task automatic test_extremes;
    logic [2:0] exp_second;
`ifdef CMP_SIGNED_EN
    exp_second = 3'b100;
`else
    exp_second = 3'b010;
`endif
    // Pointer is 2: requester 1 is reached after wrapping past 2,3,0
    set_lane(1, 16'hFFFF, 16'hFFFF);
    req = 4'b0010;
    tick;
    total_checks++;
    if (grant !== 4'b0010) begin
      $display("FAIL ext_grant_eq: grant=%b required 0010", grant);
    end else pass_checks++;
    req = '0;
    tick;
    total_checks++;
    if (done !== 1'b1 || result_id !== 2'd1 || {gt, lt, eq} !== 3'b001) begin
      $display("FAIL ext_eq: done=%b id=%0d gtlteq=%b required 1 1 001", done, result_id, {gt, lt, eq});
    end else pass_checks++;
    set_lane(3, 16'h0000, 16'hFFFF);
    req = 4'b1000;
    tick;
    total_checks++;
    if (grant !== 4'b1000) begin
      $display("FAIL ext_grant_lt: grant=%b required 1000", grant);
    end else pass_checks++;
    req = '0;
    tick;
    total_checks++;
    if (done !== 1'b1 || result_id !== 2'd3 || {gt, lt, eq} !== exp_second) begin
      $display("FAIL ext_zero_vs_ffff: done=%b id=%0d gtlteq=%b required 1 3 %b",
               done, result_id, {gt, lt, eq}, exp_second);
    end else pass_checks++;
    tick;
  endtask

  task automatic test_mid_reset;
    logic saw_activity;
    // Pointer is 0 here; the grant to 0 moves it to 1 before the reset hits
    set_lane(0, 16'h0001, 16'h0002);
    req = 4'b0001;
    tick;
    total_checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      $display("FAIL mid_load: grant=%b busy=%b required 0001 1", grant, busy);
    end else pass_checks++;
    #2 n_rst = 1'b0;
    #1;
    total_checks++;
    if ({grant, busy, done, result_id, gt, lt, eq} !== '0) begin
      $display("FAIL mid_reset_outputs: got %b required 0", {grant, busy, done, result_id, gt, lt, eq});
    end else pass_checks++;
    saw_activity = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (done !== 1'b0 || grant !== 4'b0000) saw_activity = 1'b1;
    end
    total_checks++;
    if (saw_activity !== 1'b0) begin
      $display("FAIL mid_reset_no_done: activity=%b required 0", saw_activity);
    end else pass_checks++;
    set_lane(3, 16'h0009, 16'h0009);
    req   = 4'b1001;
    n_rst = 1'b1;
    tick;
    total_checks++;
    if (grant !== 4'b0001) begin
      $display("FAIL post_reset_grant: grant=%b required 0001", grant);
    end else pass_checks++;
    req = '0;
    tick;
    total_checks++;
    if (done !== 1'b1 || result_id !== 2'd0 || {gt, lt, eq} !== 3'b010) begin
      $display("FAIL post_reset_done: done=%b id=%0d gtlteq=%b required 1 0 010",
               done, result_id, {gt, lt, eq});
    end else pass_checks++;
    tick;
    total_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL post_reset_idle: busy=%b done=%b required 0 0", busy, done);
    end else pass_checks++;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_wrap_skip;
    test_extremes;
    test_mid_reset;
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
`default_nettype wire
